// File: rtl/arbiter_out_credit_pkg.sv
// Shared router definitions: one-hot direction encoding and credit defaults.
// Used by the output-side arbiter and its credit counter.
package arbiter_out_credit_pkg;

    localparam int DEF_CREDIT_W   = 2;
    localparam int DEF_CREDIT_MAX = 3;

    // Same one-hot encoding as the input-side arbiter.
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        North = 6'b000010,
        East  = 6'b000100,
        West  = 6'b001000,
        South = 6'b010000,
        Local = 6'b100000
    } dir_t;

    function automatic dir_t idx2dir(input logic [2:0] i);
        dir_t d;
        case (i)
            3'd0:    d = North;
            3'd1:    d = East;
            3'd2:    d = West;
            3'd3:    d = South;
            3'd4:    d = Local;
            default: d = IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arbiter_out_credit_credit_counter.sv
// Downstream credit tracker for one output port.
// Sticky error flags a credit returned while already full.
module credit_counter
    import arbiter_out_credit_pkg::*;
#(
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                credit_in,
    input  logic                grant_any,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_err
);

    localparam logic [CREDIT_W-1:0] L_MAX = CREDIT_W'(CREDIT_MAX);

    logic [CREDIT_W-1:0] r_cnt;
    logic                r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= L_MAX;
            r_err <= 1'b0;
        end else if (credit_in && !grant_any) begin
            if (r_cnt == L_MAX) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (!credit_in && grant_any) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign credit_cnt = r_cnt;
    assign credit_err = r_err;

endmodule

// File: rtl/arbiter_out_credit.sv
// Output-port arbiter: rotating-priority owner FSM with credit-gated,
// zero-latency one-hot grants.
module arbiter_out_credit
    import arbiter_out_credit_pkg::*;
#(
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                X_N_Y,
    input  logic                X_E_Y,
    input  logic                X_W_Y,
    input  logic                X_S_Y,
    input  logic                X_L_Y,
    input  logic                credit_in,
    output logic                grant_Y_N,
    output logic                grant_Y_E,
    output logic                grant_Y_W,
    output logic                grant_Y_S,
    output logic                grant_Y_L,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_err
);

    dir_t       r_state;
    dir_t       w_next;
    logic [4:0] w_req;
    logic [2:0] w_start;
    logic [3:0] w_sum;
    logic [2:0] w_idx;
    logic       w_found;
    logic       w_ok;
    logic       w_grant_any;

    assign w_req = {X_L_Y, X_S_Y, X_W_Y, X_E_Y, X_N_Y};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Current owner heads the priority list; invalid codes behave as Local.
    always_comb begin
        w_start = 3'd4;
        case (r_state)
            IDLE, North: w_start = 3'd0;
            East:        w_start = 3'd1;
            West:        w_start = 3'd2;
            South:       w_start = 3'd3;
            default:     w_start = 3'd4;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_found = 1'b0;
        w_sum   = 4'd0;
        w_idx   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            w_sum = {1'b0, w_start} + 4'(k);
            w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_next  = idx2dir(w_idx);
            end
        end
    end

    assign w_ok = reset && (credit_cnt != '0);

    assign grant_Y_N = w_ok && X_N_Y && (w_next == North);
    assign grant_Y_E = w_ok && X_E_Y && (w_next == East);
    assign grant_Y_W = w_ok && X_W_Y && (w_next == West);
    assign grant_Y_S = w_ok && X_S_Y && (w_next == South);
    assign grant_Y_L = w_ok && X_L_Y && (w_next == Local);

    assign w_grant_any = grant_Y_N | grant_Y_E | grant_Y_W
                       | grant_Y_S | grant_Y_L;

    credit_counter #(
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .credit_in  (credit_in),
        .grant_any  (w_grant_any),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

endmodule
